// File: rtl/rah_pkt_pkg.sv
// Shared constants, header field layout, FSM state type and helpers for the RAH packet packer.
// The optional stall timeout is built only when RAH_PKT_TIMEOUT_EN is defined.
package rah_pkt_pkg;

  localparam int RAH_PACKET_WIDTH       = 48;
  localparam int SEL_WIDTH              = 7;
  localparam int LEN_WIDTH              = 7;
  localparam int REM_WIDTH              = LEN_WIDTH + 1;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  localparam int HDR_SEL_LSB  = 41;
  localparam int HDR_CFG_BIT  = 40;
  localparam int HDR_LEN_LSB  = 33;
  localparam int HDR_RSVD_BIT = 32;

  localparam int HDR_BYTES  = 4;
  localparam int DATA_BYTES = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT
  } state_e;

  typedef logic [RAH_PACKET_WIDTH-1:0] frame_t;
  typedef logic [REM_WIDTH-1:0]        rem_t;

  function automatic frame_t make_header(input logic [SEL_WIDTH-1:0] sel,
                                         input logic                 cfg,
                                         input logic [LEN_WIDTH-1:0] len);
    frame_t f;
    f = '0;
    f[HDR_SEL_LSB +: SEL_WIDTH] = sel;
    f[HDR_CFG_BIT]              = cfg;
    f[HDR_LEN_LSB +: LEN_WIDTH] = len;
    f[HDR_RSVD_BIT]             = 1'b0;
    return f;
  endfunction

  function automatic rem_t min_rem(input rem_t a, input rem_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rah_pkt_if.sv
// Command, byte-stream and FIFO-write signals of the RAH packet packer.
// master = packer side, slave = host/FIFO side.
interface rah_pkt_if;
  import rah_pkt_pkg::*;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [SEL_WIDTH-1:0]        cmd_slv_sel;
  logic                        cmd_cfg;
  logic [LEN_WIDTH-1:0]        cmd_len;
  logic                        in_valid;
  logic                        in_ready;
  logic [7:0]                  in_data;
  logic                        fifo_full;
  logic                        fifo_wr_en;
  logic [RAH_PACKET_WIDTH-1:0] fifo_wr_data;
  logic                        busy;
  logic                        err_timeout;

  modport master (
    input  cmd_valid, cmd_slv_sel, cmd_cfg, cmd_len, in_valid, in_data, fifo_full,
    output cmd_ready, in_ready, fifo_wr_en, fifo_wr_data, busy, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_slv_sel, cmd_cfg, cmd_len, in_valid, in_data, fifo_full,
    input  cmd_ready, in_ready, fifo_wr_en, fifo_wr_data, busy, err_timeout
  );

endinterface

// File: rtl/rah_pkt_timer.sv
// Stall counter: counts cycles while run is high, fires on the TIMEOUT_CYCLES-th one.
// Compiled only when RAH_PKT_TIMEOUT_EN is defined.
`ifdef RAH_PKT_TIMEOUT_EN
module rah_pkt_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic fire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  assign fire = run && (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear || fire) begin
      count_q <= '0;
    end else if (run) begin
      count_q <= count_q + CW'(1);
    end
  end
endmodule
`endif

// File: rtl/rah_pkt_packer.sv
// Frames a command plus byte stream into one header and N data frames of RAH packets.
// RAH_PKT_TIMEOUT_EN adds a stall timeout that zero-pads and flushes the declared frames.
module rah_pkt_packer
  import rah_pkt_pkg::*;
`ifdef RAH_PKT_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
`endif
(
  input  logic      clk,
  input  logic      rst,
  rah_pkt_if.master bus
);

  state_e     state_q;
  frame_t     frame_q;
  rem_t       rem_q;
  logic [2:0] lane_q;
  logic       hdr_q;
  logic       frame_rdy_q;
  logic       pad_q;
  logic       cmd_ready_q;
  logic       busy_q;
  logic       err_q;

  logic [2:0] cap;
  logic [5:0] shift;
  rem_t       take_now;
  rem_t       take_pad;
  logic       frame_done;
  logic       cmd_fire;
  logic       byte_fire;
  logic       timer_fire;

  // Header frames hold 4 payload bytes in [31:0], data frames 6 in [47:0], first byte highest.
  assign cap        = hdr_q ? 3'(HDR_BYTES) : 3'(DATA_BYTES);
  assign shift      = (hdr_q ? 6'd24 : 6'd40) - {lane_q, 3'b000};
  assign take_now   = min_rem(rem_q, rem_t'(cap - lane_q));
  assign take_pad   = min_rem(rem_q, rem_t'(cap));
  assign frame_done = (lane_q == cap - 3'd1) || (rem_q == rem_t'(1));

  assign cmd_fire  = bus.cmd_valid && cmd_ready_q;
  assign byte_fire = bus.in_valid && bus.in_ready;

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.in_ready     = (state_q == ST_COLLECT) && !frame_rdy_q && !pad_q && (rem_q != '0);
  assign bus.fifo_wr_en   = frame_rdy_q && !bus.fifo_full;
  assign bus.fifo_wr_data = frame_q;
  assign bus.busy         = busy_q;
  assign bus.err_timeout  = err_q;

`ifdef RAH_PKT_TIMEOUT_EN
  logic stall;
  logic stall_clear;

  assign stall       = bus.in_ready && !bus.in_valid;
  assign stall_clear = (state_q != ST_COLLECT) || byte_fire;

  rah_pkt_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (stall),
    .clear(stall_clear),
    .fire (timer_fire)
  );
`else
  assign timer_fire = 1'b0;
`endif

  // NOTE: every register here uses <= so all next-state values derive from the pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      rem_q       <= '0;
      lane_q      <= '0;
      hdr_q       <= 1'b0;
      frame_rdy_q <= 1'b0;
      pad_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            frame_q     <= make_header(bus.cmd_slv_sel, bus.cmd_cfg, bus.cmd_len);
            rem_q       <= {1'b0, bus.cmd_len};
            lane_q      <= '0;
            hdr_q       <= 1'b1;
            pad_q       <= 1'b0;
            state_q     <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (rem_q == '0) begin
            frame_rdy_q <= 1'b1;
            state_q     <= ST_EMIT;
          end else if (pad_q) begin
            // After a timeout each remaining frame goes out as zeros, consuming its quota.
            rem_q       <= rem_q - take_pad;
            frame_rdy_q <= 1'b1;
            state_q     <= ST_EMIT;
          end else if (byte_fire) begin
            frame_q <= frame_q | (frame_t'(bus.in_data) << shift);
            rem_q   <= rem_q - rem_t'(1);
            lane_q  <= lane_q + 3'd1;
            if (frame_done) begin
              frame_rdy_q <= 1'b1;
              state_q     <= ST_EMIT;
            end
          end else if (timer_fire) begin
            err_q       <= 1'b1;
            rem_q       <= rem_q - take_now;
            pad_q       <= 1'b1;
            frame_rdy_q <= 1'b1;
            state_q     <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (bus.fifo_wr_en) begin
            frame_rdy_q <= 1'b0;
            if (rem_q == '0) begin
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              frame_q <= '0;
              lane_q  <= '0;
              hdr_q   <= 1'b0;
              state_q <= ST_COLLECT;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rah_pkt_packer.md
# rah_pkt_packer

Host-side framer that produces the 48-bit RAH packets consumed by the periplex decoder input FIFO. It accepts a per-transfer command (slave select, cfg flag, byte length) and a byte stream. It emits one header frame followed by data frames, writing each frame into the downstream FIFO under full-flag backpressure. It is the writer for the packet stream that the periplex decoder reads.

## Interface
- RAH_PACKET_WIDTH, 48, frame width written to FIFO
- SEL_WIDTH, 7, slave select field width
- LEN_WIDTH, 7, byte-length field width
- TIMEOUT_CYCLES, 1024, stall limit (only with RAH_PKT_TIMEOUT_EN)

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  transfer command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_slv_sel  in  SEL_WIDTH  target slave id
- cmd_cfg  in  1  1 = configuration transfer, 0 = data
- cmd_len  in  LEN_WIDTH  payload bytes, 0..127
- in_valid  in  1  payload byte present
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_data  in  8  payload byte
- fifo_full  in  1  downstream FIFO full
- fifo_wr_en  out  1  write strobe
- fifo_wr_data  out  RAH_PACKET_WIDTH  frame
- busy  out  1  transfer in progress
- err_timeout  out  1  one-cycle pulse; driven 0 without the macro

## Operation
- Header frame: [47:41] slv_sel, [40] cfg, [39:33] len, [32] reserved 0, [31:0] payload bytes 0..3, with byte0 at [31:24].
- Data frames carry 6 bytes each, first byte at [47:40]. Unused byte lanes are zero.
- Frame count = 1 + ceil(max(len−4,0)/6). len=0 produces a header-only frame with a zero payload. len=4 produces a header only. len=5 produces header + 1 data frame.
- FSM states:
  - IDLE: cmd_ready=1. Accepting a command latches its fields, clears the byte counter, goes to COLLECT.
  - COLLECT: in_ready = !frame_rdy. Bytes shift into the frame register. When the frame's byte quota is reached, or len=0 at the header, set frame_rdy and go to EMIT.
  - EMIT: fifo_wr_en = frame_rdy && !fifo_full. On write, clear frame_rdy. Go to COLLECT if bytes remain, else IDLE.
- The remaining-byte counter is LEN_WIDTH+1 wide, decremented per accepted byte, and never underflows. Bytes are not accepted once it reaches 0.
- busy=1 from command accept until the final frame is written.
- Reset values: cmd_ready=0 during rst, then 1 in IDLE. in_ready=0, fifo_wr_en=0, fifo_wr_data=0, busy=0, err_timeout=0.
- Reset mid-transfer discards the partial frame with no further writes. After reset, bytes are ignored until a new command is accepted.

## Timing
- cmd_ready and in_ready are registered-state derived. fifo_wr_en is the combinational AND of the frame_rdy register with !fifo_full.
- A byte accepted in cycle N that completes a frame → frame_rdy in N+1 → fifo_wr_en in N+1 if fifo_full=0.
- fifo_full held high keeps fifo_wr_data stable and fifo_wr_en low, for an unbounded time.
- Throughput: one byte per cycle within a frame, plus one bubble cycle per frame for EMIT.
- A new command may be accepted the cycle after the last write (back in IDLE), giving a minimum 1-cycle gap between transfers.
- cmd_valid during a transfer is ignored (cmd_ready=0).

## Configuration
- RAH_PKT_TIMEOUT_EN defined:
  - A counter runs in COLLECT while in_valid=0. It resets on every accepted byte.
  - At TIMEOUT_CYCLES the current frame is zero-padded and emitted. The remaining frames are emitted as zero frames, keeping the frame count as declared.
  - err_timeout pulses for 1 cycle when the timeout fires.
- RAH_PKT_TIMEOUT_EN undefined: no counter; COLLECT waits indefinitely; err_timeout is tied to 0.

## Structure
- Shared package rah_pkt_pkg: width constants, header field offsets, header byte capacity (4), data byte capacity (6), FSM state enum.
- Optional sub-module rah_pkt_timer (stall counter with a fire pulse), instantiated only under RAH_PKT_TIMEOUT_EN.

## Test plan
- slv_sel=0x05, cfg=1, len=3, bytes 11 22 33 → single write 0x0B06_1122_3300.
- len=10, bytes 01..0A, fifo_full=0 → header [31:0]=0x01020304, then data 0x0506_0708_090A.
- len=0 → exactly one header frame with [31:0]=0; busy falls after that write.
- len=5 with fifo_full high for 20 cycles at the header → wr_data is held stable, there are no writes during that window, and there are 2 writes total.
- Reset asserted after 2 of 8 bytes → no write occurs; after release, cmd_ready=1 and busy=0.
- RAH_PKT_TIMEOUT_EN, TIMEOUT_CYCLES=16, len=8, source stops after 2 bytes:
  - err_timeout pulses once.
  - Header [31:0]=b0 b1 00 00.
  - One zero data frame follows.
